// File: rtl/demux_collector_pkg.sv
// demux_collector_pkg: shared channel tags, default width and arbiter state encoding for the demux collector
package demux_pkg;
  localparam logic CHAN_B = 1'b0;
  localparam logic CHAN_C = 1'b1;
  localparam int DEF_WIDTH = 2;
  typedef enum logic {LAST_B = 1'b0, LAST_C = 1'b1} arb_t;
endpackage

// File: rtl/demux_collector_if.sv
// demux_collector_if: demux lines B/C in, tagged merged stream out (master = environment, slave = collector)
interface demux_collector_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] inB;
  logic             inB_vld;
  logic [WIDTH-1:0] inC;
  logic             inC_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             fullB;
  logic             fullC;
  modport master (
    output inB, inB_vld, inC, inC_vld, out_ready,
    input  out_data, out_chan, out_valid, fullB, fullC
  );
  modport slave (
    input  inB, inB_vld, inC, inC_vld, out_ready,
    output out_data, out_chan, out_valid, fullB, fullC
  );
endinterface

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: per-channel sync FIFO; ports clk, rst_n, i_push/i_data in, i_pop in, o_data/o_full/o_empty out
module demux_chan_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_wen;
  logic             w_ren;
  // full when the pointers differ only in the wrap bit
  assign o_full  = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign o_empty = r_wr == r_rd;
  assign w_wen   = i_push & ~o_full;
  assign w_ren   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wen) r_wr <= r_wr + 1'b1;
      if (w_ren) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/demux_collector.sv
// demux_collector: buffers demux lines B/C in two FIFOs and merges them round-robin into one tagged valid/ready stream
// Ports: clk, rst_n (async active-low), bus (demux_collector_if.slave).
// With DEMUX_COLLECTOR_DROP_CNT_EN defined: drop_clr in, dropB_cnt/dropC_cnt saturating drop counters out.
module demux_collector
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef DEMUX_COLLECTOR_DROP_CNT_EN
  input  logic                   drop_clr,
  output logic [CNT_W-1:0]       dropB_cnt,
  output logic [CNT_W-1:0]       dropC_cnt,
`endif
  demux_collector_if.slave       bus
);
  arb_t             r_state;
  arb_t             w_state_nxt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_chan;
  logic             w_ld;
  logic             w_popB;
  logic             w_popC;
  logic             w_emptyB;
  logic             w_emptyC;
  logic [WIDTH-1:0] w_dB;
  logic [WIDTH-1:0] w_dC;

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .i_push(bus.inB_vld), .i_data(bus.inB), .i_pop(w_popB),
    .o_data(w_dB), .o_full(bus.fullB), .o_empty(w_emptyB)
  );
  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_c (
    .clk(clk), .rst_n(rst_n), .i_push(bus.inC_vld), .i_data(bus.inC), .i_pop(w_popC),
    .o_data(w_dC), .o_full(bus.fullC), .o_empty(w_emptyC)
  );

  // output register reloads when empty or when its word is being taken
  assign w_ld = ~r_valid | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LAST_C;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_popB ? LAST_B : w_popC ? LAST_C : r_state;
  end

  // when both channels hold data, grant the one not served last
  always_comb begin
    w_popB = w_ld & ~w_emptyB & (w_emptyC | (r_state == LAST_C));
    w_popC = w_ld & ~w_emptyC & (w_emptyB | (r_state == LAST_B));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= CHAN_B;
    end else if (w_ld) begin
      r_valid <= w_popB | w_popC;
      if (w_popB | w_popC) begin
        r_data <= w_popC ? w_dC : w_dB;
        r_chan <= w_popC ? CHAN_C : CHAN_B;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_chan  = r_chan;

`ifdef DEMUX_COLLECTOR_DROP_CNT_EN
  logic [CNT_W-1:0] r_dropB_cnt;
  logic [CNT_W-1:0] r_dropC_cnt;
  logic             w_dropB;
  logic             w_dropC;
  assign w_dropB = bus.inB_vld & bus.fullB;
  assign w_dropC = bus.inC_vld & bus.fullC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropB_cnt <= '0;
      r_dropC_cnt <= '0;
    end else begin
      r_dropB_cnt <= drop_clr ? '0 : (w_dropB & ~&r_dropB_cnt) ? r_dropB_cnt + 1'b1 : r_dropB_cnt;
      r_dropC_cnt <= drop_clr ? '0 : (w_dropC & ~&r_dropC_cnt) ? r_dropC_cnt + 1'b1 : r_dropC_cnt;
    end
  end
  assign dropB_cnt = r_dropB_cnt;
  assign dropC_cnt = r_dropC_cnt;
`endif
endmodule
